// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, control-word layout and field encodings shared by the control pipeline
package ctrl_pkg;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
    localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_CSR       = 7'b1110011;

    localparam int CW = 13;

    localparam int F_REG_WRITE  = 0;
    localparam int F_ALU_SRC_A  = 1;
    localparam int F_ALU_SRC_B  = 3;
    localparam int F_MEM_WRITE  = 5;
    localparam int F_MEM_READ   = 6;
    localparam int F_MEM_TO_REG = 7;
    localparam int F_PC_SRC     = 8;
    localparam int F_ALU_OP     = 10;
    localparam int F_CSR_WE     = 12;

    localparam logic [1:0] SRC_A_RS1  = 2'b00;
    localparam logic [1:0] SRC_A_ZERO = 2'b01;
    localparam logic [1:0] SRC_A_PC   = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JAL    = 2'b10;
    localparam logic [1:0] PC_JALR   = 2'b11;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_RTYPE  = 2'b10;
    localparam logic [1:0] ALU_ITYPE  = 2'b11;

    // Packed MSB-first, so reg_write lands on bit 0 of the control word
    typedef struct packed {
        logic       csr_we;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] alu_src_b;
        logic [1:0] alu_src_a;
        logic       reg_write;
    } ctrl_word_t;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode/rd to control word, register-use flags and illegal flag (CSR opcode legal only with CTRL_PIPE_CSR_EN)
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int RD_W = 5
) (
    input  logic [6:0]      opcode,
    input  logic [RD_W-1:0] rd,
    output logic [CW-1:0]   ctrl,
    output logic            uses_rs1,
    output logic            uses_rs2,
    output logic            illegal
);

    ctrl_word_t cw;
    logic       wr;

    // Per-opcode field table; writes to x0 are suppressed after the lookup
    always_comb begin
        cw       = '0;
        wr       = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OPC_LUI: begin
                wr = 1'b1;
                cw.alu_src_a = SRC_A_ZERO;
                cw.alu_src_b = SRC_B_IMM;
            end
            OPC_AUIPC: begin
                wr = 1'b1;
                cw.alu_src_a = SRC_A_PC;
                cw.alu_src_b = SRC_B_IMM;
            end
            OPC_JAL: begin
                wr = 1'b1;
                cw.alu_src_a = SRC_A_PC;
                cw.alu_src_b = SRC_B_FOUR;
                cw.pc_src    = PC_JAL;
            end
            OPC_JALR: begin
                wr = 1'b1;
                uses_rs1 = 1'b1;
                cw.alu_src_a = SRC_A_PC;
                cw.alu_src_b = SRC_B_FOUR;
                cw.pc_src    = PC_JALR;
            end
            OPC_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                cw.pc_src = PC_BRANCH;
                cw.alu_op = ALU_BRANCH;
            end
            OPC_LOAD: begin
                wr = 1'b1;
                uses_rs1 = 1'b1;
                cw.alu_src_b  = SRC_B_IMM;
                cw.mem_read   = 1'b1;
                cw.mem_to_reg = 1'b1;
            end
            OPC_STORE: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                cw.alu_src_b = SRC_B_IMM;
                cw.mem_write = 1'b1;
            end
            OPC_ARI_ITYPE: begin
                wr = 1'b1;
                uses_rs1 = 1'b1;
                cw.alu_src_b = SRC_B_IMM;
                cw.alu_op    = ALU_ITYPE;
            end
            OPC_ARI_RTYPE: begin
                wr = 1'b1;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                cw.alu_op = ALU_RTYPE;
            end
`ifdef CTRL_PIPE_CSR_EN
            OPC_CSR: begin
                wr = 1'b1;
                uses_rs1 = 1'b1;
                cw.alu_src_b = SRC_B_IMM;
                cw.csr_we    = 1'b1;
            end
`endif
            default: illegal = 1'b1;
        endcase
        cw.reg_write = wr & (rd != '0);
    end

    assign ctrl = cw;

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: RV32I decode control word carried through STAGES registers with load-use stall, flush and memory freeze (CSR decode via CTRL_PIPE_CSR_EN)
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int RD_W   = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   dec_valid,
    input  logic [6:0]             dec_opcode,
    input  logic [RD_W-1:0]        dec_rd,
    input  logic [RD_W-1:0]        dec_rs1,
    input  logic [RD_W-1:0]        dec_rs2,
    output logic                   dec_ready,
    output logic                   dec_illegal,
    input  logic                   flush,
    input  logic                   mem_ready,
    output logic                   stall,
    output logic [STAGES-1:0]      pipe_valid,
    output logic [STAGES*CW-1:0]   pipe_ctrl,
    output logic [STAGES*RD_W-1:0] pipe_rd
);

    logic [CW-1:0]   dec_ctrl;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            illegal;
    logic            take;
    logic [STAGES-1:0] vld;
    logic [CW-1:0]   ctl [STAGES];
    logic [RD_W-1:0] rdq [STAGES];

    ctrl_decode #(.RD_W(RD_W)) u_decode (
        .opcode   (dec_opcode),
        .rd       (dec_rd),
        .ctrl     (dec_ctrl),
        .uses_rs1 (uses_rs1),
        .uses_rs2 (uses_rs2),
        .illegal  (illegal)
    );

    assign dec_illegal = dec_valid & illegal;
    assign stall = dec_valid & vld[0] & ctl[0][F_MEM_READ] & (rdq[0] != '0) &
                   ((uses_rs1 & (rdq[0] == dec_rs1)) | (uses_rs2 & (rdq[0] == dec_rs2)));
    assign take      = dec_valid & ~flush & ~stall;
    assign dec_ready = rst_n & mem_ready & dec_valid & (flush | ~stall);

    // Shift the control pipe on every advance cycle; stage 0 gets the decoded word or a zero bubble
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 0; i < STAGES; i++) begin
                ctl[i] <= '0;
                rdq[i] <= '0;
            end
        end else if (mem_ready) begin
            vld    <= {vld[STAGES-2:0], take};
            ctl[0] <= take ? dec_ctrl : '0;
            rdq[0] <= take ? dec_rd : '0;
            for (int i = 1; i < STAGES; i++) begin
                ctl[i] <= ctl[i-1];
                rdq[i] <= rdq[i-1];
            end
        end
    end

    assign pipe_valid = vld;

    for (genvar g = 0; g < STAGES; g++) begin : g_out
        assign pipe_ctrl[CW*g +: CW]     = ctl[g];
        assign pipe_rd[RD_W*g +: RD_W]   = rdq[g];
    end

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed and randomized checks of ctrl_pipe against a behavioural model (honours CTRL_PIPE_CSR_EN)
module tb_ctrl_pipe;
    import ctrl_pkg::*;

    localparam int S = 3;
    localparam int R = 5;

    logic           clk = 1'b0;
    logic           rst_n, dec_valid, flush, mem_ready;
    logic [6:0]     opc;
    logic [R-1:0]   rd, rs1, rs2;
    logic           dec_ready, dec_illegal, stall;
    logic [S-1:0]   pipe_valid;
    logic [S*13-1:0] pipe_ctrl;
    logic [S*R-1:0] pipe_rd;

    int n_tests = 0;
    int n_fail  = 0;

    logic          m_v [S];
    logic [12:0]   m_c [S];
    logic [R-1:0]  m_r [S];

    logic [6:0]    ops [10];
    logic [S-1:0]  sv;
    logic [S*13-1:0] sc;
    logic [S*R-1:0]  sr;

    ctrl_pipe #(.STAGES(S), .RD_W(R)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dec_valid   (dec_valid),
        .dec_opcode  (opc),
        .dec_rd      (rd),
        .dec_rs1     (rs1),
        .dec_rs2     (rs2),
        .dec_ready   (dec_ready),
        .dec_illegal (dec_illegal),
        .flush       (flush),
        .mem_ready   (mem_ready),
        .stall       (stall),
        .pipe_valid  (pipe_valid),
        .pipe_ctrl   (pipe_ctrl),
        .pipe_rd     (pipe_rd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {illegal, uses_rs2, uses_rs1, control word} from the opcode table
    function automatic logic [15:0] ref_dec(input logic [6:0] op, input logic [R-1:0] d);
        int rw = 0, a = 0, b = 0, mw = 0, mr = 0, pc = 0, alu = 0, csr = 0;
        logic u1 = 0, u2 = 0, ill = 0;
        int cw;
        case (op)
            OPC_LUI:       begin rw = 1; a = 1; b = 1; end
            OPC_AUIPC:     begin rw = 1; a = 2; b = 1; end
            OPC_JAL:       begin rw = 1; a = 2; b = 2; pc = 2; end
            OPC_JALR:      begin rw = 1; a = 2; b = 2; pc = 3; u1 = 1; end
            OPC_BRANCH:    begin pc = 1; alu = 1; u1 = 1; u2 = 1; end
            OPC_LOAD:      begin rw = 1; b = 1; mr = 1; u1 = 1; end
            OPC_STORE:     begin b = 1; mw = 1; u1 = 1; u2 = 1; end
            OPC_ARI_ITYPE: begin rw = 1; b = 1; alu = 3; u1 = 1; end
            OPC_ARI_RTYPE: begin rw = 1; alu = 2; u1 = 1; u2 = 1; end
`ifdef CTRL_PIPE_CSR_EN
            OPC_CSR:       begin rw = 1; b = 1; csr = 1; u1 = 1; end
`endif
            default:       ill = 1;
        endcase
        cw = csr * 4096 + alu * 1024 + pc * 256 + mr * 128 + mr * 64 + mw * 32 + b * 8 + a * 2
             + ((rw == 1 && d != 0) ? 1 : 0);
        return {ill, u2, u1, cw[12:0]};
    endfunction

    task automatic drive(input logic r, input logic v, input logic [6:0] op, input logic [R-1:0] d,
                         input logic [R-1:0] s1, input logic [R-1:0] s2, input logic fl, input logic mr);
        rst_n = r; dec_valid = v; opc = op; rd = d; rs1 = s1; rs2 = s2; flush = fl; mem_ready = mr;
    endtask

    task automatic step(input logic r, input logic v, input logic [6:0] op, input logic [R-1:0] d,
                        input logic [R-1:0] s1, input logic [R-1:0] s2, input logic fl, input logic mr);
        logic [15:0] dv;
        logic e_stall, e_ready, tk;
        logic [S-1:0] ev;
        logic [S*13-1:0] ec;
        logic [S*R-1:0] er;
        drive(r, v, op, d, s1, s2, fl, mr);
        @(negedge clk);
        dv = ref_dec(op, d);
        e_stall = v && m_v[0] && m_c[0][6] && m_r[0] != 0 &&
                  ((dv[13] && m_r[0] == s1) || (dv[14] && m_r[0] == s2));
        e_ready = r && mr && v && (fl || !e_stall);
        for (int i = 0; i < S; i++) begin
            ev[i] = m_v[i];
            ec[13*i +: 13] = m_c[i];
            er[R*i +: R] = m_r[i];
        end
        check("stall", stall, e_stall);
        check("dec_ready", dec_ready, e_ready);
        check("dec_illegal", dec_illegal, v && dv[15]);
        check("pipe_valid", pipe_valid, ev);
        check("pipe_ctrl", pipe_ctrl, ec);
        check("pipe_rd", pipe_rd, er);
        tk = v && !fl && !e_stall;
        @(posedge clk);
        if (!r) begin
            for (int i = 0; i < S; i++) begin m_v[i] = 0; m_c[i] = 0; m_r[i] = 0; end
        end else if (mr) begin
            for (int i = S - 1; i > 0; i--) begin m_v[i] = m_v[i-1]; m_c[i] = m_c[i-1]; m_r[i] = m_r[i-1]; end
            m_v[0] = tk;
            m_c[0] = tk ? dv[12:0] : 13'd0;
            m_r[0] = tk ? d : '0;
        end
        #1;
    endtask

    initial begin
        int k;
        logic [6:0] rop;
        ops = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE,
                OPC_ARI_ITYPE, OPC_ARI_RTYPE, OPC_CSR};
        for (int i = 0; i < S; i++) begin m_v[i] = 0; m_c[i] = 0; m_r[i] = 0; end
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        @(posedge clk); #1;
        step(0, 1, OPC_LOAD, 1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check("rst_valid", pipe_valid, 0);
        check("rst_ctrl", pipe_ctrl, 0);
        check("rst_rd", pipe_rd, 0);

        step(1, 1, OPC_ARI_RTYPE, 3, 1, 2, 0, 1);
        check("arir_v0", pipe_valid, 3'b001);
        check("arir_rw", pipe_ctrl[0], 1);
        check("arir_aluop", pipe_ctrl[11:10], 2);
        check("arir_srcb", pipe_ctrl[4:3], 0);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        check("arir_v2", pipe_valid[2], 1);
        check("arir_rd2", pipe_rd[14:10], 3);

        step(1, 1, OPC_LOAD, 5, 0, 0, 0, 1);
        drive(1, 1, OPC_ARI_ITYPE, 6, 5, 0, 0, 1); #1;
        check("lu_stall", stall, 1);
        check("lu_ready", dec_ready, 0);
        step(1, 1, OPC_ARI_ITYPE, 6, 5, 0, 0, 1);
        check("lu_bubble", pipe_valid[1:0], 2'b10);
        step(1, 1, OPC_ARI_ITYPE, 6, 5, 0, 0, 1);
        check("lu_after", pipe_valid, 3'b101);

        step(1, 1, OPC_LOAD, 0, 1, 0, 0, 1);
        check("ld0_rw", pipe_ctrl[0], 0);
        drive(1, 1, OPC_ARI_RTYPE, 4, 1, 0, 0, 1); #1;
        check("ld0_nostall", stall, 0);
        step(1, 1, OPC_ARI_RTYPE, 4, 1, 0, 0, 1);

        step(1, 1, OPC_LOAD, 5, 0, 0, 0, 1);
        drive(1, 1, OPC_ARI_ITYPE, 6, 5, 0, 1, 1); #1;
        check("fl_stall_ready", dec_ready, 1);
        step(1, 1, OPC_ARI_ITYPE, 6, 5, 0, 1, 1);
        check("fl_bubble", pipe_valid[0], 0);

        step(1, 1, OPC_BRANCH, 0, 1, 2, 0, 1);
        step(1, 1, OPC_ARI_RTYPE, 7, 1, 2, 1, 1);
        check("br_bubble", pipe_valid[0], 0);
        check("br_v1", pipe_valid[1], 1);
        check("br_pc", pipe_ctrl[22:21], 1);

        step(1, 1, OPC_ARI_RTYPE, 1, 2, 3, 0, 1);
        step(1, 1, OPC_ARI_RTYPE, 2, 3, 4, 0, 1);
        step(1, 1, OPC_ARI_RTYPE, 3, 4, 5, 0, 1);
        sv = pipe_valid; sc = pipe_ctrl; sr = pipe_rd;
        check("frz_full", sv, 3'b111);
        repeat (3) begin
            drive(1, 1, OPC_ARI_ITYPE, 4, 1, 0, 1, 0); #1;
            check("frz_ready", dec_ready, 0);
            step(1, 1, OPC_ARI_ITYPE, 4, 1, 0, 1, 0);
            check("frz_valid", pipe_valid, sv);
            check("frz_ctrl", pipe_ctrl, sc);
            check("frz_rd", pipe_rd, sr);
        end
        drive(1, 1, OPC_ARI_ITYPE, 4, 1, 0, 1, 1); #1;
        check("frz_rel_ready", dec_ready, 1);
        step(1, 1, OPC_ARI_ITYPE, 4, 1, 0, 1, 1);
        check("frz_flush", pipe_valid, 3'b110);

        drive(1, 1, OPC_CSR, 7, 1, 0, 0, 1); #1;
`ifdef CTRL_PIPE_CSR_EN
        check("csr_illegal", dec_illegal, 0);
        step(1, 1, OPC_CSR, 7, 1, 0, 0, 1);
        check("csr_we", pipe_ctrl[12], 1);
        check("csr_rw", pipe_ctrl[0], 1);
`else
        check("csr_illegal", dec_illegal, 1);
        step(1, 1, OPC_CSR, 7, 1, 0, 0, 1);
        check("csr_ctrl", pipe_ctrl[12:0], 0);
        check("csr_valid", pipe_valid[0], 1);
`endif

        repeat (800) begin
            k = $urandom_range(0, 11);
            rop = 7'($urandom);
            step($urandom_range(0, 49) != 0, $urandom_range(0, 4) != 0, k < 10 ? ops[k] : rop,
                 R'($urandom_range(0, 3)), R'($urandom_range(0, 3)), R'($urandom_range(0, 3)),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 4) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
